// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the BRAM port-A arbiter.
package mem_arb_pkg;

  // Requester identifiers; REQ_NONE doubles as "no outstanding read".
  typedef enum logic [1:0] {
    REQ_F    = 2'd0,
    REQ_LS   = 2'd1,
    REQ_IO   = 2'd2,
    REQ_NONE = 2'd3
  } req_id_e;

  // Arbiter state: IDLE (no access), GRANT (access issued), LOCKED (ls owns port).
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GRANT  = 2'd1,
    ST_LOCKED = 2'd2
  } arb_state_e;

  localparam int unsigned DEF_STARVE_LIMIT = 32'd4;

endpackage

// File: rtl/mem_arb_select.sv
// Combinational winner pick for the BRAM port arbiter.
module mem_arb_select
  import mem_arb_pkg::*;
(
  input  logic    f_req_i,
  input  logic    ls_req_i,
  input  logic    io_req_i,
  input  logic    io_starved_i,
  input  logic    locked_i,
  output req_id_e win_o
);

  // Lock owner only while locked; otherwise starved io first, then ls > fetch > io.
  always_comb begin
    win_o = REQ_NONE;
    if (locked_i) begin
      if (ls_req_i) begin
        win_o = REQ_LS;
      end else begin
        win_o = REQ_NONE;
      end
    end else if (io_starved_i && io_req_i) begin
      win_o = REQ_IO;
    end else if (ls_req_i) begin
      win_o = REQ_LS;
    end else if (f_req_i) begin
      win_o = REQ_F;
    end else if (io_req_i) begin
      win_o = REQ_IO;
    end else begin
      win_o = REQ_NONE;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Registered priority-plus-aging arbiter sharing BRAM port A between
// fetch, load/store and an I/O master, with an ls lock for RMW sequences.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W       = 32'd16,
  parameter int unsigned DATA_W       = 32'd16,
  parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              f_req_i,
  input  logic [ADDR_W-1:0] f_addr_i,
  input  logic              ls_req_i,
  input  logic [ADDR_W-1:0] ls_addr_i,
  input  logic              ls_we_i,
  input  logic [DATA_W-1:0] ls_wdata_i,
  input  logic              ls_lock_i,
  input  logic              io_req_i,
  input  logic [ADDR_W-1:0] io_addr_i,
  input  logic              io_we_i,
  input  logic [DATA_W-1:0] io_wdata_i,
  output logic              f_gnt_o,
  output logic              ls_gnt_o,
  output logic              io_gnt_o,
  output logic              f_rvalid_o,
  output logic              ls_rvalid_o,
  output logic              io_rvalid_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic              mem_we_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              locked_o
);

  localparam logic [3:0] AGE_LIMIT = 4'(STARVE_LIMIT);

  arb_state_e        state_q;
  req_id_e           owner_q;
  req_id_e           win_id;
  logic [3:0]        io_age_q;
  logic [2:0]        gnt_q;
  logic [2:0]        rvalid_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              mem_we_q;

  mem_arb_select u_select (
    .f_req_i      (f_req_i),
    .ls_req_i     (ls_req_i),
    .io_req_i     (io_req_i),
    .io_starved_i (io_age_q == AGE_LIMIT),
    .locked_i     (state_q == ST_LOCKED),
    .win_o        (win_id)
  );

  // Issue the winning access on mem_*, track the outstanding read, age io and run the lock FSM.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      owner_q     <= REQ_NONE;
      io_age_q    <= 4'd0;
      gnt_q       <= 3'b000;
      rvalid_q    <= 3'b000;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
    end else begin
      gnt_q    <= 3'b000;
      mem_we_q <= 1'b0;
      owner_q  <= REQ_NONE;

      // Read issued last cycle returns now; owner tag says whose it is.
      rvalid_q[0] <= (owner_q == REQ_F);
      rvalid_q[1] <= (owner_q == REQ_LS);
      rvalid_q[2] <= (owner_q == REQ_IO);

      // io waits age toward promotion; a grant or a dropped request restarts the count.
      if (io_req_i && (win_id != REQ_IO)) begin
        if (io_age_q < AGE_LIMIT) begin
          io_age_q <= io_age_q + 4'd1;
        end else begin
          io_age_q <= io_age_q;
        end
      end else begin
        io_age_q <= 4'd0;
      end

      case (win_id)
        REQ_F: begin
          gnt_q[0]   <= 1'b1;
          mem_addr_q <= f_addr_i;
          owner_q    <= REQ_F;
          state_q    <= ST_GRANT;
        end
        REQ_LS: begin
          gnt_q[1]   <= 1'b1;
          mem_addr_q <= ls_addr_i;
          mem_we_q   <= ls_we_i;
          if (ls_we_i) begin
            mem_wdata_q <= ls_wdata_i;
            owner_q     <= REQ_NONE;
          end else begin
            owner_q     <= REQ_LS;
          end
          state_q <= ls_lock_i ? ST_LOCKED : ST_GRANT;
        end
        REQ_IO: begin
          gnt_q[2]   <= 1'b1;
          mem_addr_q <= io_addr_i;
          mem_we_q   <= io_we_i;
          if (io_we_i) begin
            mem_wdata_q <= io_wdata_i;
            owner_q     <= REQ_NONE;
          end else begin
            owner_q     <= REQ_IO;
          end
          state_q <= ST_GRANT;
        end
        default: begin
          // No access: the lock survives idle cycles, otherwise fall back to IDLE.
          state_q <= (state_q == ST_LOCKED) ? ST_LOCKED : ST_IDLE;
        end
      endcase
    end
  end

  assign f_gnt_o     = gnt_q[0];
  assign ls_gnt_o    = gnt_q[1];
  assign io_gnt_o    = gnt_q[2];
  assign f_rvalid_o  = rvalid_q[0];
  assign ls_rvalid_o = rvalid_q[1];
  assign io_rvalid_o = rvalid_q[2];
  assign rdata_o     = mem_rdata_i;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign mem_we_o    = mem_we_q;
  assign locked_o    = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus random
// traffic compared every cycle against a behavioural model of the arbiter.
module tb_mem_port_arbiter;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        f_req, ls_req, io_req, ls_we, io_we, ls_lock;
  logic [15:0] f_addr, ls_addr, io_addr, ls_wdata, io_wdata;
  logic        f_gnt, ls_gnt, io_gnt, f_rvalid, ls_rvalid, io_rvalid;
  logic [15:0] rdata, mem_addr, mem_wdata, mem_rdata;
  logic        mem_we, locked;

  int total = 0;
  int bad   = 0;

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .STARVE_LIMIT(LIMIT)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .f_req_i(f_req), .f_addr_i(f_addr),
    .ls_req_i(ls_req), .ls_addr_i(ls_addr), .ls_we_i(ls_we), .ls_wdata_i(ls_wdata), .ls_lock_i(ls_lock),
    .io_req_i(io_req), .io_addr_i(io_addr), .io_we_i(io_we), .io_wdata_i(io_wdata),
    .f_gnt_o(f_gnt), .ls_gnt_o(ls_gnt), .io_gnt_o(io_gnt),
    .f_rvalid_o(f_rvalid), .ls_rvalid_o(ls_rvalid), .io_rvalid_o(io_rvalid),
    .rdata_o(rdata), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_we_o(mem_we),
    .mem_rdata_i(mem_rdata), .locked_o(locked)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] init_val(int i);
    case (i)
      16'h10:  return 16'hABCD;
      16'h30:  return 16'h5A5A;
      16'h40:  return 16'h1111;
      16'h41:  return 16'h2222;
      16'h42:  return 16'h3333;
      default: return 16'(i * 263);
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // BRAM behaviour: one-cycle read latency, read-first, sampled at the rising edge.
  logic [15:0] bram [0:255];
  initial begin
    for (int i = 0; i < 256; i++) bram[i] = init_val(i);
    mem_rdata = 16'h0000;
    forever begin
      @(posedge clk);
      mem_rdata = bram[mem_addr[7:0]];
      if (mem_we) bram[mem_addr[7:0]] = mem_wdata;
    end
  end

  // Behavioural model: expected outputs for the cycle that follows each edge.
  logic [15:0] ref_mem [0:255];
  int          m_pend;
  logic [15:0] m_pend_data;
  int          m_age;
  logic        m_locked;
  logic [2:0]  e_gnt, e_rv;
  logic        e_we;
  logic [15:0] e_addr, e_wdata, e_rdata;
  int          win;
  logic [2:0]  reqv;
  logic [15:0] a, d;
  logic        w;
  int          order [3] = '{1, 0, 2};

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
    m_pend = -1; m_age = 0; m_locked = 1'b0;
    e_gnt = 3'b000; e_rv = 3'b000; e_we = 1'b0;
    e_addr = 16'h0000; e_wdata = 16'h0000; e_rdata = 16'h0000;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_pend = -1; m_age = 0; m_locked = 1'b0;
        e_gnt = 3'b000; e_rv = 3'b000; e_we = 1'b0;
        e_addr = 16'h0000; e_wdata = 16'h0000;
      end else begin
        e_rv = 3'b000;
        if (m_pend >= 0) begin
          e_rv[m_pend] = 1'b1;
          e_rdata = m_pend_data;
        end
        m_pend = -1;
        reqv = {io_req, ls_req, f_req};
        win = -1;
        if (m_locked) begin
          if (ls_req) win = 1;
        end else if (io_req && m_age == LIMIT) begin
          win = 2;
        end else begin
          for (int k = 0; k < 3; k++)
            if (win < 0 && reqv[order[k]]) win = order[k];
        end
        e_gnt = 3'b000;
        e_we  = 1'b0;
        if (win >= 0) begin
          e_gnt[win] = 1'b1;
          case (win)
            0:       begin a = f_addr;  w = 1'b0;  d = 16'h0000; end
            1:       begin a = ls_addr; w = ls_we; d = ls_wdata; end
            default: begin a = io_addr; w = io_we; d = io_wdata; end
          endcase
          e_addr = a;
          if (w) begin
            e_we = 1'b1;
            e_wdata = d;
            ref_mem[a[7:0]] = d;
          end else begin
            m_pend = win;
            m_pend_data = ref_mem[a[7:0]];
          end
          if (win == 1) m_locked = ls_lock;
        end
        if (io_req && win != 2) begin
          if (m_age < LIMIT) m_age++;
        end else begin
          m_age = 0;
        end
      end
    end
  end

  // Compare DUT outputs against the model on the falling edge of every cycle.
  initial begin
    forever begin
      @(negedge clk);
      chk("gnt", {29'd0, io_gnt, ls_gnt, f_gnt}, {29'd0, e_gnt});
      chk("rvalid", {29'd0, io_rvalid, ls_rvalid, f_rvalid}, {29'd0, e_rv});
      chk("mem_we", {31'd0, mem_we}, {31'd0, e_we});
      chk("mem_addr", {16'd0, mem_addr}, {16'd0, e_addr});
      chk("locked", {31'd0, locked}, {31'd0, m_locked});
      if (e_we) chk("mem_wdata", {16'd0, mem_wdata}, {16'd0, e_wdata});
      if (e_rv != 3'b000) chk("rdata", {16'd0, rdata}, {16'd0, e_rdata});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    f_req = 1'b0; ls_req = 1'b0; io_req = 1'b0;
    ls_we = 1'b0; io_we = 1'b0; ls_lock = 1'b0;
  endtask

  int got;

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    f_addr = 16'h0; ls_addr = 16'h0; io_addr = 16'h0; ls_wdata = 16'h0; io_wdata = 16'h0;
    step(); step();
    chk("rst_gnt", {29'd0, io_gnt, ls_gnt, f_gnt}, 32'd0);
    chk("rst_mem", {mem_we, mem_addr, mem_wdata}, 32'd0);
    chk("rst_locked", {31'd0, locked}, 32'd0);
    rst_n = 1'b1;
    step();

    // Single fetch read.
    f_req = 1'b1; f_addr = 16'h0010;
    step();
    chk("fetch_gnt", {29'd0, io_gnt, ls_gnt, f_gnt}, 32'd1);
    chk("fetch_addr", {16'd0, mem_addr}, 32'h10);
    f_req = 1'b0;
    step();
    chk("fetch_rvalid", {31'd0, f_rvalid}, 32'd1);
    chk("fetch_rdata", {16'd0, rdata}, 32'hABCD);

    // Contention: ls write beats fetch, fetch follows.
    f_req = 1'b1; f_addr = 16'h0011;
    ls_req = 1'b1; ls_we = 1'b1; ls_addr = 16'h0020; ls_wdata = 16'h1234;
    step();
    chk("cont_ls_gnt", {29'd0, io_gnt, ls_gnt, f_gnt}, 32'd2);
    chk("cont_we", {31'd0, mem_we}, 32'd1);
    ls_req = 1'b0; ls_we = 1'b0;
    step();
    chk("cont_f_gnt", {29'd0, io_gnt, ls_gnt, f_gnt}, 32'd1);
    chk("cont_bram", {16'd0, bram[8'h20]}, 32'h1234);
    f_req = 1'b0;
    step();

    // Starvation: io waits while ls/fetch alternate.
    io_req = 1'b1; io_we = 1'b0; io_addr = 16'h0060;
    ls_req = 1'b1; ls_addr = 16'h0061; f_req = 1'b0; f_addr = 16'h0062;
    got = 0;
    for (int k = 1; k <= 8; k++) begin
      step();
      if (io_gnt && got == 0) got = k;
      ls_req = ~ls_req; f_req = ~f_req;
      if (got != 0) begin io_req = 1'b0; break; end
    end
    chk("starve_wait", got, 32'd5);
    idle_inputs();
    step(); step();

    // Lock RMW with fetch held.
    f_req = 1'b1; f_addr = 16'h0050;
    ls_req = 1'b1; ls_addr = 16'h0030; ls_we = 1'b0; ls_lock = 1'b1;
    step();
    chk("lock_gnt", {29'd0, io_gnt, ls_gnt, f_gnt}, 32'd2);
    chk("lock_on", {31'd0, locked}, 32'd1);
    ls_req = 1'b0;
    step();
    chk("lock_hold", {30'd0, locked, f_gnt}, 32'd2);
    chk("lock_rdata", {15'd0, ls_rvalid, rdata}, {15'd0, 1'b1, 16'h5A5A});
    ls_req = 1'b1; ls_we = 1'b1; ls_wdata = 16'hA5A5; ls_lock = 1'b0;
    step();
    chk("unlock_gnt", {29'd0, io_gnt, ls_gnt, f_gnt}, 32'd2);
    chk("unlock_off", {30'd0, locked, mem_we}, 32'd1);
    ls_req = 1'b0; ls_we = 1'b0;
    step();
    chk("after_lock_f", {29'd0, io_gnt, ls_gnt, f_gnt}, 32'd1);
    chk("rmw_bram", {16'd0, bram[8'h30]}, 32'hA5A5);
    f_req = 1'b0;
    step(); step();

    // Back-to-back ls reads.
    ls_req = 1'b1; ls_addr = 16'h0040;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("b2b_gnt", {15'd0, ls_gnt, mem_addr}, {15'd0, 1'b1, 16'(16'h40 + i)});
      if (i > 0) chk("b2b_rd", {15'd0, ls_rvalid, rdata}, {15'd0, 1'b1, init_val(16'h40 + i - 1)});
      if (i < 2) ls_addr = 16'(16'h41 + i);
      else ls_req = 1'b0;
    end
    step();
    chk("b2b_last", {15'd0, ls_rvalid, rdata}, {15'd0, 1'b1, 16'h3333});
    step();

    // Reset during the grant cycle of a fetch read.
    f_req = 1'b1; f_addr = 16'h0010;
    step();
    chk("rr_gnt", {31'd0, f_gnt}, 32'd1);
    f_req = 1'b0; rst_n = 1'b0;
    step();
    chk("rr_rvalid", {29'd0, io_rvalid, ls_rvalid, f_rvalid}, 32'd0);
    chk("rr_outs", {mem_we, mem_addr, mem_wdata}, 32'd0);
    rst_n = 1'b1;
    step();
    chk("rr_after", {26'd0, locked, f_rvalid, mem_we, io_gnt, ls_gnt, f_gnt}, 32'd0);

    // Random traffic; requesters hold until granted, then re-roll.
    for (int c = 0; c < 3000; c++) begin
      step();
      if (!f_req || f_gnt) begin
        f_req = ($urandom_range(0, 1) == 0);
        f_addr = 16'($urandom);
      end
      if (!ls_req || ls_gnt) begin
        ls_req = ($urandom_range(0, 1) == 0);
        ls_addr = 16'($urandom); ls_we = 1'($urandom);
        ls_wdata = 16'($urandom); ls_lock = ($urandom_range(0, 3) == 0);
      end
      if (!io_req || io_gnt) begin
        io_req = ($urandom_range(0, 2) == 0);
        io_addr = 16'($urandom); io_we = 1'($urandom); io_wdata = 16'($urandom);
      end
    end
    idle_inputs();
    step(); step(); step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single BRAM port A between three requesters: instruction fetch (PC → IR), load/store (ls path), and an external I/O/debug master. It replaces the fixed `ls_mux` selection with a registered, priority-plus-aging arbiter. Every access is a one-beat request/grant handshake with pipelined read-data return. A lock is provided for atomic load-store read-modify-write sequences.

## Interface
- ADDR_W, 16, address width to BRAM
- DATA_W, 16, data width
- STARVE_LIMIT, 4, cycles an I/O request may wait before it is promoted to top priority (1..15)
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- f_req / ls_req / io_req  in  1 each  access request, held until granted
- f_addr / ls_addr / io_addr  in  ADDR_W each  access address
- ls_we / io_we  in  1 each  write strobe; fetch is read-only
- ls_wdata / io_wdata  in  DATA_W each  write data
- ls_lock  in  1  hold grant for the next ls access (RMW)
- f_gnt / ls_gnt / io_gnt  out  1 each  one-cycle pulse, request accepted
- f_rvalid / ls_rvalid / io_rvalid  out  1 each  read data valid for that requester
- rdata  out  DATA_W  read data, equal to mem_rdata
- mem_addr  out  ADDR_W  BRAM address, registered
- mem_wdata  out  DATA_W  BRAM write data, registered
- mem_we  out  1  BRAM write enable, registered
- mem_rdata  in  DATA_W  BRAM q_a (one-cycle read latency)
- locked  out  1  arbiter is in LOCKED state

## Operation
- States: IDLE (no grant this cycle), GRANT (access issued this cycle), LOCKED (ls owns port).
- Winner selection each cycle, from requests sampled at the edge:
  - Normal order: ls > fetch > io.
  - If io_age == STARVE_LIMIT, io wins over both others.
- io_age (4-bit):
  - increments each cycle io_req=1 and io not granted; saturates at STARVE_LIMIT.
  - clears on io grant or when io_req=0.
- Grant: winner's gnt pulses in the cycle its access is driven on mem_*. Losers keep req asserted.
- Reads: rvalid for the granted requester is delivered exactly one cycle after its gnt. A 2-bit registered owner tag tracks the outstanding read.
- Writes: mem_we=1 for one cycle with the gnt; no rvalid is produced.
- Lock:
  - An ls grant with ls_lock=1 enters LOCKED.
  - In LOCKED only ls is granted; fetch and io stall, and io_age keeps counting but cannot preempt.
  - The ls grant with ls_lock=0 leaves LOCKED after that access.
- No request pending: mem_we=0; mem_addr holds its last value; state=IDLE.
- Back-to-back accesses by any mix of requesters are allowed, at one access per cycle.

## Timing
- Request seen high at edge N → gnt, mem_addr/mem_we/mem_wdata valid in cycle N+1 → BRAM samples at end of N+1 → rvalid and rdata in cycle N+2.
- Latency req→gnt is 1 cycle minimum. req→rvalid is 2 cycles.
- A requester drops req or changes addr in the cycle after gnt. Holding req after gnt is a new request.
- Reset values: all gnt and rvalid 0, mem_we 0, mem_addr 0, mem_wdata 0, locked 0, io_age 0, state IDLE, owner tag none.
- Reset asserted mid-operation drops any pending rvalid. No write is issued while reset=0.
- Simultaneous requests: exactly one gnt per cycle. Never two rvalids in the same cycle.
- io promotion at STARVE_LIMIT is suppressed while locked. Promotion takes effect on the first unlocked cycle.

## Structure
- Shared package mem_arb_pkg holds:
  - requester IDs REQ_F=0, REQ_LS=1, REQ_IO=2, REQ_NONE=3;
  - state encoding IDLE/GRANT/LOCKED;
  - default STARVE_LIMIT.
- One sub-module, mem_arb_select: combinational winner pick from {reqs, io_age==limit, locked} → requester ID. All registers stay in the top.

## Test plan
- Single fetch read: f_req=1 with f_addr=0x0010, BRAM[0x10]=0xABCD → f_gnt in cycle 1, f_rvalid with rdata=0xABCD in cycle 2, no other gnt.
- Contention: f_req and ls_req both high, ls_we=1, ls_addr=0x0020, ls_wdata=0x1234 → ls_gnt first with mem_we=1; f_gnt the next cycle; BRAM[0x20]=0x1234.
- Starvation: io_req held while ls_req and f_req toggle continuously, STARVE_LIMIT=4 → io_gnt no later than the 5th cycle after io_req rises, then io_age=0.
- Lock RMW: ls read with ls_lock=1 at 0x0030, then ls write with ls_lock=0, while f_req is held → locked=1 between them, no f_gnt until after the ls write gnt.
- Reset mid-read: reset low in the cycle after f_gnt → f_rvalid never asserts, all outputs read 0, state IDLE after release.
- Back-to-back: ls reads at 0x40, 0x41, 0x42 on consecutive cycles → three consecutive ls_rvalid with the matching data, no bubbles.
